// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared phase encoding, field widths and LFSR constants for the pong blocks
package pong_pkg;

    localparam int SCORE_W = 4;
    localparam int SPEED_W = 5;
    localparam int LFSR_W  = 5;

    // x^5 + x^3 + 1: feedback taps on bits 4 and 2 of a left-shifting register
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_SERVE    = 3'd1,
        PH_PLAY     = 3'd2,
        PH_POINT    = 3'd3,
        PH_GAMEOVER = 3'd4
    } phase_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - control/event link between the game sequencer and the ball engine
interface pong_game_ctrl_if;
    import pong_pkg::*;

    logic                       ball_reset;
    logic signed [SPEED_W-1:0]  speed;
    logic [LFSR_W-1:0]          entropy;
    logic                       out_left;
    logic                       out_right;

    modport master (output ball_reset, output speed, output entropy,
                    input  out_left, input out_right);
    modport slave  (input  ball_reset, input speed, input entropy,
                    output out_left, output out_right);
endinterface

// File: rtl/lfsr5.sv
// rtl/lfsr5.sv - free-running 5-bit Fibonacci LFSR with synchronous seed on reset
module lfsr5
    import pong_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] state
);

    // Step every cycle; the seed is nonzero so the all-zero lockup state is never entered
    always_ff @(posedge clk) begin
        if (reset) state <= LFSR_SEED;
        else       state <= lfsr_next(state);
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - match sequencer: serve/rally/point/game-over phases, scoring and speed ramp
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 2000,
    parameter int POINT_TICKS = 1000,
    parameter int SPEED_INIT  = 4,
    parameter int SPEED_MAX   = 15,
    parameter int RAMP_TICKS  = 4000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    pong_game_ctrl_if.master    ball,
    output logic [SCORE_W-1:0]  lscore,
    output logic [SCORE_W-1:0]  rscore,
    output logic                game_over,
    output logic                winner,
    output logic [2:0]          phase
);

    localparam int T_MAX0 = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int T_MAX  = (T_MAX0 > RAMP_TICKS) ? T_MAX0 : RAMP_TICKS;
    localparam int TW     = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] SERVE_LAST = TW'(SERVE_TICKS - 1);
    localparam logic [TW-1:0] POINT_LAST = TW'(POINT_TICKS - 1);
    localparam logic [TW-1:0] RAMP_LAST  = TW'(RAMP_TICKS - 1);

    localparam logic signed [SPEED_W-1:0] SPD_INIT = SPEED_W'(SPEED_INIT);
    localparam logic signed [SPEED_W-1:0] SPD_MAX  = SPEED_W'(SPEED_MAX);
    localparam logic [SCORE_W-1:0]        SCORE_WIN = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0]        SCORE_SAT = '1;

    phase_e                     state, state_n;
    logic [TW-1:0]              timer, timer_n;
    logic signed [SPEED_W-1:0]  speed_q, speed_n;
    logic [SCORE_W-1:0]         lscore_n, rscore_n;
    logic [SCORE_W-1:0]         lscore_inc, rscore_inc;
    logic                       game_over_n, winner_n;
    logic                       start_q, start_rise;
    logic                       ball_reset_q;
    logic [LFSR_W-1:0]          lfsr_q;

    assign start_rise = start & ~start_q;
    assign lscore_inc = (lscore == SCORE_SAT) ? SCORE_SAT : lscore + SCORE_W'(1);
    assign rscore_inc = (rscore == SCORE_SAT) ? SCORE_SAT : rscore + SCORE_W'(1);

    lfsr5 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr_q)
    );

    assign ball.entropy    = lfsr_q;
    assign ball.speed      = speed_q;
    assign ball.ball_reset = ball_reset_q;
    assign phase           = state;

    // State and datapath registers; ball_reset trails the phase by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= PH_IDLE;
            timer        <= '0;
            speed_q      <= '0;
            lscore       <= '0;
            rscore       <= '0;
            game_over    <= 1'b0;
            winner       <= 1'b0;
            start_q      <= 1'b0;
            ball_reset_q <= 1'b1;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            speed_q      <= speed_n;
            lscore       <= lscore_n;
            rscore       <= rscore_n;
            game_over    <= game_over_n;
            winner       <= winner_n;
            start_q      <= start;
            ball_reset_q <= (state != PH_PLAY);
        end
    end

    // Phase sequencing, scoring, timer and speed ramp
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        speed_n     = speed_q;
        lscore_n    = lscore;
        rscore_n    = rscore;
        game_over_n = game_over;
        winner_n    = winner;
        case (state)
            PH_IDLE, PH_GAMEOVER: begin
                if (start_rise) begin
                    state_n     = PH_SERVE;
                    timer_n     = '0;
                    speed_n     = SPD_INIT;
                    lscore_n    = '0;
                    rscore_n    = '0;
                    game_over_n = 1'b0;
                end
            end
            PH_SERVE: begin
                if (timer == SERVE_LAST) begin
                    state_n = PH_PLAY;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            PH_PLAY: begin
                // A simultaneous double exit is credited to the right player
                if (ball.out_left) begin
                    rscore_n = rscore_inc;
                    if (rscore_inc == SCORE_WIN) begin
                        state_n     = PH_GAMEOVER;
                        game_over_n = 1'b1;
                        winner_n    = 1'b1;
                    end else begin
                        state_n = PH_POINT;
                        timer_n = '0;
                    end
                end else if (ball.out_right) begin
                    lscore_n = lscore_inc;
                    if (lscore_inc == SCORE_WIN) begin
                        state_n     = PH_GAMEOVER;
                        game_over_n = 1'b1;
                        winner_n    = 1'b0;
                    end else begin
                        state_n = PH_POINT;
                        timer_n = '0;
                    end
                end else if (timer == RAMP_LAST) begin
                    timer_n = '0;
                    speed_n = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + SPEED_W'(1);
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            PH_POINT: begin
                if (timer == POINT_LAST) begin
                    state_n = PH_SERVE;
                    timer_n = '0;
                    speed_n = SPD_INIT;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = PH_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - randomized bench for pong_game_ctrl against a behavioural match model
module tb_pong_game_ctrl;
    import pong_pkg::*;

    localparam int WIN = 2;
    localparam int ST  = 4;
    localparam int PT  = 3;
    localparam int SI  = 4;
    localparam int SM  = 15;
    localparam int RT  = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] lscore, rscore;
    logic       game_over, winner;
    logic [2:0] phase;

    pong_game_ctrl_if bif();

    pong_game_ctrl #(
        .WIN_SCORE(WIN), .SERVE_TICKS(ST), .POINT_TICKS(PT),
        .SPEED_INIT(SI), .SPEED_MAX(SM), .RAMP_TICKS(RT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ball      (bif),
        .lscore    (lscore),
        .rscore    (rscore),
        .game_over (game_over),
        .winner    (winner),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference match state
    int m_ph, m_br, m_spd, m_ls, m_rs, m_go, m_win, m_cnt, m_play, m_sq;
    logic [4:0] m_lfsr;
    bit seen [32];

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit ol, input bit orr);
        bit rise;
        int br_n;
        if (r) begin
            m_ph = 0; m_br = 1; m_spd = 0; m_ls = 0; m_rs = 0;
            m_go = 0; m_win = 0; m_cnt = 0; m_play = 0; m_sq = 0;
            m_lfsr = 5'b00001;
            return;
        end
        rise = s && (m_sq == 0);
        br_n = (m_ph != 2) ? 1 : 0;
        case (m_ph)
            0, 4: if (rise) begin
                m_ph = 1; m_ls = 0; m_rs = 0; m_go = 0; m_spd = SI; m_cnt = 0;
            end
            1: begin
                m_cnt++;
                if (m_cnt == ST) begin m_ph = 2; m_play = 0; end
            end
            2: begin
                if (ol) begin
                    m_rs = sat15(m_rs + 1);
                    if (m_rs == WIN) begin m_ph = 4; m_go = 1; m_win = 1; end
                    else begin m_ph = 3; m_cnt = 0; end
                end else if (orr) begin
                    m_ls = sat15(m_ls + 1);
                    if (m_ls == WIN) begin m_ph = 4; m_go = 1; m_win = 0; end
                    else begin m_ph = 3; m_cnt = 0; end
                end else begin
                    m_play++;
                    m_spd = SI + m_play / RT;
                    if (m_spd > SM) m_spd = SM;
                end
            end
            3: begin
                m_cnt++;
                if (m_cnt == PT) begin m_ph = 1; m_cnt = 0; m_spd = SI; end
            end
            default: m_ph = 0;
        endcase
        m_sq = s;
        m_br = br_n;
        // Sequence recurrence of x^5+x^3+1: new bit = bit(n-5) xor bit(n-3)
        m_lfsr = {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
    endtask

    task automatic cycle(input bit r, input bit s, input bit ol, input bit orr);
        reset = r; start = s; bif.out_left = ol; bif.out_right = orr;
        @(posedge clk);
        model_step(r, s, ol, orr);
        #1;
        chk("phase",      int'(phase), m_ph);
        chk("ball_reset", int'(bif.ball_reset), m_br);
        chk("speed",      int'(bif.speed), m_spd);
        chk("entropy",    int'(bif.entropy), int'(m_lfsr));
        chk("lscore",     int'(lscore), m_ls);
        chk("rscore",     int'(rscore), m_rs);
        chk("game_over",  int'(game_over), m_go);
        if (m_go != 0) chk("winner", int'(winner), m_win);
        seen[bif.entropy] = 1'b1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic wait_play();
        int k;
        k = 0;
        while (m_ph != 2 && k < 50) begin
            cycle(0, 0, 0, 0);
            k++;
        end
        if (m_ph != 2) chk("wait_play_timeout", k, -1);
    endtask

    initial begin
        int cov;
        reset = 1'b1; start = 1'b0; bif.out_left = 1'b0; bif.out_right = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        for (int i = 0; i < 32; i++) seen[i] = 1'b0;

        // First match: long rally to saturate the speed, then a double exit
        cycle(0, 1, 0, 0);
        quiet(4);
        quiet(70);
        cycle(0, 0, 1, 1);
        wait_play();
        quiet(2);
        cycle(0, 0, 0, 1);
        wait_play();
        quiet(3);
        // Reset mid-rally with lscore=1, then let the LFSR run a full period
        cycle(1, 0, 0, 0);
        quiet(40);

        // Second match to game over, ignored exits, restart from game over
        cycle(0, 1, 0, 0);
        wait_play();
        cycle(0, 0, 1, 0);
        wait_play();
        quiet(7);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);
        quiet(2);
        cycle(0, 1, 0, 0);
        quiet(3);

        // Randomized play, including start held across reset and stray exits
        for (int i = 0; i < 2500; i++) begin
            cycle(($urandom_range(0, 399) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 29) == 0));
        end

        cov = 0;
        for (int i = 1; i < 32; i++) if (seen[i]) cov++;
        chk("lfsr_cover", cov, 31);
        chk("lfsr_zero", int'(seen[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
